// File: rtl/seg_scan_ctrl.sv
`timescale 1ns / 1ps
// seg_scan_ctrl
// Multi-digit seven-segment scanner. An internal prescaler chooses how long
// each digit is selected. At the start of each digit slot there is a short
// window with every anode off, which stops the previous digit ghosting.
// Display data comes from shadow registers that are updated only on a load
// strobe. All outputs are registered.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   data       hex nibbles; nibble i drives digit i (digit 0 is rightmost)
//   dp_in      decimal point request per digit
//   load       captures data/dp_in into the shadow registers
//   mode       0 hex, 1 hex with leading-zero blanking, 2 blank, 3 lamp test
//   seg        segments {g,f,e,d,c,b,a}
//   an         digit anodes
//   dp         decimal point
//   frame_tick one-cycle pulse after the digit index wraps back to 0
module seg_scan_ctrl #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 131072,
  parameter int BLANK_CYC  = 1024,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [1:0]            mode,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ONE   = IW'(1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);

  // Internal logic is low-true; INV flips everything for high-true boards.
  localparam logic              INV     = (ACTIVE_LOW == 0) ? 1'b1 : 1'b0;
  localparam logic [6:0]        SEG_INV = {7{INV}};
  localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{INV}};

  typedef enum logic [1:0] {
    MODE_HEX   = 2'd0,
    MODE_LZB   = 2'd1,
    MODE_BLANK = 2'd2,
    MODE_LAMP  = 2'd3
  } mode_t;

  // Low-true hex to segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CW-1:0]       cnt_r;
  logic [IW-1:0]       idx_r;
  logic [4*DIGITS-1:0] shadow_data_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   an_r;
  logic                dp_r;
  logic                frame_tick_r;

  logic                cnt_end_s;
  logic                idx_end_s;
  logic [3:0]          nib_s;
  logic                dp_sel_s;
  logic                lz_s;
  logic [6:0]          seg_low_s;
  logic [DIGITS-1:0]   an_low_s;
  logic                dp_low_s;

  assign cnt_end_s = (cnt_r == CNT_LAST);
  assign idx_end_s = (idx_r == IDX_LAST);
  assign nib_s     = shadow_data_r[{idx_r, 2'b00} +: 4];
  assign dp_sel_s  = shadow_dp_r[idx_r];

  // Prescaler and digit index; the index steps on the last count of a slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (cnt_end_s) begin
      cnt_r <= '0;
      if (idx_end_s) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Shadow registers decouple the display from the data source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_data_r <= '0;
      shadow_dp_r   <= '0;
    end else if (load) begin
      shadow_data_r <= data;
      shadow_dp_r   <= dp_in;
    end else begin
      shadow_data_r <= shadow_data_r;
      shadow_dp_r   <= shadow_dp_r;
    end
  end

  // Leading-zero detect: set when the selected nibble and every higher one are 0.
  always_comb begin
    lz_s = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      lz_s = lz_s & ~((j >= int'(idx_r)) && (shadow_data_r[j*4 +: 4] != 4'h0));
    end
  end

  // Next low-true output pattern for the currently selected digit.
  always_comb begin
    seg_low_s = 7'h7F;
    dp_low_s  = 1'b1;
    an_low_s  = {DIGITS{1'b1}};
    if (cnt_r >= CNT_BLANK) begin
      an_low_s = ~(AN_ONE << idx_r);
    end else begin
      an_low_s = {DIGITS{1'b1}};
    end
    case (mode_t'(mode))
      MODE_HEX: begin
        seg_low_s = decode_hex(nib_s);
        dp_low_s  = ~dp_sel_s;
      end
      MODE_LZB: begin
        // Digit 0 always shows, so a zero value still reads "0".
        if (lz_s && (idx_r != '0)) begin
          seg_low_s = 7'h7F;
        end else begin
          seg_low_s = decode_hex(nib_s);
        end
        dp_low_s = ~dp_sel_s;
      end
      MODE_BLANK: begin
        seg_low_s = 7'h7F;
        dp_low_s  = 1'b1;
      end
      MODE_LAMP: begin
        seg_low_s = 7'h00;
        dp_low_s  = 1'b0;
      end
      default: begin
        seg_low_s = 7'h7F;
        dp_low_s  = 1'b1;
      end
    endcase
  end

  // Output registers; frame_tick marks the edge where the index wrapped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r        <= 7'h7F ^ SEG_INV;
      an_r         <= {DIGITS{1'b1}} ^ AN_INV;
      dp_r         <= 1'b1 ^ INV;
      frame_tick_r <= 1'b0;
    end else begin
      seg_r        <= seg_low_s ^ SEG_INV;
      an_r         <= an_low_s ^ AN_INV;
      dp_r         <= dp_low_s ^ INV;
      frame_tick_r <= cnt_end_s & idx_end_s;
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign dp         = dp_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns / 1ps
// Testbench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1).
// The stimulus queues the expected outputs for each sample cycle, and a monitor
// compares them on the falling clock edge. Slot position p is counted from the
// first rising edge after reset release: cnt=p%8, idx=(p/8)%4.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        load;
  logic [1:0]  mode;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   base     = 0;

  seg_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .load(load),
    .mode(mode), .seg(seg), .an(an), .dp(dp), .frame_tick(frame_tick)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop entries due at this sample cycle and compare.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc < cyc) begin
        failures++;
        $display("FAIL %s missed: actual cyc=%0d required cyc=%0d", mon_e.tag, cyc, mon_e.cyc);
      end else if ({seg, an, dp, frame_tick} !== {mon_e.seg, mon_e.an, mon_e.dp, mon_e.ft}) begin
        failures++;
        $display("FAIL %s cyc=%0d actual seg=%h an=%b dp=%b ft=%b required seg=%h an=%b dp=%b ft=%b",
                 mon_e.tag, cyc, seg, an, dp, frame_tick, mon_e.seg, mon_e.an, mon_e.dp, mon_e.ft);
      end
    end
  end

  task automatic check_now(input string tag, input logic [12:0] req);
    checks++;
    if ({seg, an, dp, frame_tick} !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", tag, {seg, an, dp, frame_tick}, req);
    end
  endtask

  // Queue expected outputs for positions p0..p1; s0..s3 are per-digit patterns,
  // dpon marks digits whose decimal point is lit.
  task automatic push_range(input string tag, input int p0, input int p1,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpon);
    logic [6:0] s[4];
    logic [3:0] sel;
    exp_t e;
    int d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int p = p0; p <= p1; p++) begin
      d     = (p / 8) % 4;
      sel   = 4'b0001 << d;
      e.cyc = base + 1 + p;
      e.tag = tag;
      e.seg = s[d];
      e.an  = ((p % 8) >= 2) ? ~sel : 4'b1111;
      e.dp  = ~dpon[d];
      e.ft  = ((p % 32) == 31);
      sb.push_back(e);
    end
  endtask

  // Stop at the falling edge just before the rising edge at position p.
  task automatic wait_pos(input int p);
    while (cyc < base + p) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; data = 16'h0; dp_in = 4'h0; load = 1'b0; mode = 2'd0;
    @(negedge clk);
    @(negedge clk);
    check_now("reset_idle", {7'h7F, 4'hF, 1'b1, 1'b0});

    // 1: release with a load of 1234 in hex mode
    @(negedge clk);
    reset = 1'b1; data = 16'h1234; load = 1'b1; base = cyc;
    push_range("t1_preload", 0, 0, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    push_range("t1_scan", 1, 63, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
    @(negedge clk);
    load = 1'b0;

    // 2: leading-zero blanking
    wait_pos(64);
    data = 16'h00A0; mode = 2'd1; load = 1'b1;
    push_range("t2_lzb", 65, 95, 7'h40, 7'h08, 7'h7F, 7'h7F, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    wait_pos(96);
    data = 16'h0000; load = 1'b1;
    push_range("t2_zero", 97, 127, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    @(negedge clk);
    load = 1'b0;

    // 3: shadow holds without load; load on cnt==7, idx==1
    wait_pos(128);
    mode = 2'd0; data = 16'h5678; load = 1'b1;
    push_range("t3_old", 129, 143, 7'h00, 7'h78, 7'h02, 7'h12, 4'b0000);
    @(negedge clk);
    load = 1'b0; data = 16'hFFFF;
    wait_pos(143);
    load = 1'b1;
    push_range("t3_new", 144, 159, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0000);
    @(negedge clk);
    load = 1'b0;

    // 4: lamp test, then blank
    wait_pos(160);
    mode = 2'd3;
    push_range("t4_lamp", 160, 191, 7'h00, 7'h00, 7'h00, 7'h00, 4'b1111);
    wait_pos(192);
    mode = 2'd2;
    push_range("t4_blank", 192, 223, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000);

    // 5: decimal point on digit 2 only
    wait_pos(224);
    mode = 2'd0; dp_in = 4'b0100; load = 1'b1;
    push_range("t5_dp", 225, 255, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0100);
    @(negedge clk);
    load = 1'b0; dp_in = 4'b0000;

    // 6: async reset while idx=3, cnt=5
    wait_pos(285);
    check_now("t6_pre", {7'h0E, 4'b0111, 1'b1, 1'b0});
    #2 reset = 1'b0;
    #1 check_now("t6_async", {7'h7F, 4'hF, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b1; base = cyc;
    push_range("t6_restart", 0, 40, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
